// File: rtl/compact_bf_pipe.sv
// compact_bf_pipe: four-coefficient NTT/INTT butterfly pipeline, four register stages.
// Each beat runs as either two independent radix-2 butterflies or one two-layer radix-4
// butterfly. It uses Cooley-Tukey for NTT and Gentleman-Sande for INTT, with optional
// divide-by-two on every INTT layer. The mode travels with the beat, so mixed streams
// flow without a drain.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready = ~(out_valid & ~out_ready)
//   mode_r4, mode_intt    per-beat mode (radix-4, inverse transform)
//   halve                 INTT only: halve every layer output mod Q
//   a0..a3, w0..w2        coefficients and twiddles, each < Q
//   out_valid / out_ready output handshake
//   y0..y3                results, held while out_valid is low
module compact_bf_pipe #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned Q          = 12289
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode_r4,
  input  logic                  mode_intt,
  input  logic                  halve,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] a2,
  input  logic [DATA_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] w0,
  input  logic [DATA_WIDTH-1:0] w1,
  input  logic [DATA_WIDTH-1:0] w2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y0,
  output logic [DATA_WIDTH-1:0] y1,
  output logic [DATA_WIDTH-1:0] y2,
  output logic [DATA_WIDTH-1:0] y3
);

  localparam int unsigned W = DATA_WIDTH;

  typedef logic [W-1:0]   coef_t;
  typedef logic [2*W-1:0] prod_t;
  // Multiply half of a butterfly: CT keeps u, GS keeps (u+v); prod is the unreduced product.
  typedef struct packed {coef_t keep; prod_t prod;} mul_t;
  typedef struct packed {coef_t hi; coef_t lo;} pair_t;

  localparam logic [W:0] QE = (W+1)'(Q);
  localparam prod_t      QP = (2*W)'(Q);

  function automatic coef_t add_mod(coef_t a, coef_t b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QE) s = s - QE;
    return coef_t'(s);
  endfunction

  function automatic coef_t sub_mod(coef_t a, coef_t b);
    logic [W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + QE;  // wraps back into [0,Q)
    return coef_t'(s);
  endfunction

  function automatic coef_t halve_mod(coef_t x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + QE) : {1'b0, x};
    return coef_t'(s >> 1);
  endfunction

  function automatic mul_t bf_mul(logic gs, coef_t u, coef_t v, coef_t w);
    mul_t  m;
    coef_t d;
    d = sub_mod(u, v);
    if (gs) begin
      m.keep = add_mod(u, v);
      m.prod = prod_t'(d) * prod_t'(w);
    end else begin
      m.keep = u;
      m.prod = prod_t'(v) * prod_t'(w);
    end
    return m;
  endfunction

  function automatic pair_t bf_red(logic gs, logic hv, mul_t m);
    pair_t p;
    coef_t t;
    t = coef_t'(m.prod % QP);
    if (gs) begin
      p.hi = hv ? halve_mod(m.keep) : m.keep;
      p.lo = hv ? halve_mod(t) : t;
    end else begin
      p.hi = add_mod(m.keep, t);
      p.lo = sub_mod(m.keep, t);
    end
    return p;
  endfunction

  // Stage registers: 1 = L1 multiply, 2 = L1 reduce (b), 3 = L2 multiply, 4 = outputs.
  logic  v1_q, v2_q, v3_q, v4_q;
  logic  r4_1_q, gs_1_q, hv_1_q, r4_2_q, gs_2_q, hv_2_q, r4_3_q, gs_3_q, hv_3_q;
  mul_t  ma_1_q, mb_1_q, ma_3_q, mb_3_q;
  coef_t l2a_1_q, l2b_1_q, l2a_2_q, l2b_2_q;
  coef_t b_2_q [4];
  coef_t byp_3_q [4];
  coef_t y_q [4];

  mul_t  ma_1_d, mb_1_d, ma_3_d, mb_3_d;
  coef_t l2a_d, l2b_d;
  coef_t b_d [4];
  coef_t y_d [4];
  pair_t pa, pb, qa, qb;
  logic  r4_ntt;
  logic  stall;

  assign stall     = v4_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v4_q;
  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];

  // Layer 1 pairing and twiddle selection; layer-2 twiddles are chosen here and carried.
  always_comb begin
    r4_ntt = mode_r4 & ~mode_intt;
    ma_1_d = bf_mul(mode_intt, a0, r4_ntt ? a2 : a1, (mode_r4 & mode_intt) ? w1 : w0);
    mb_1_d = bf_mul(mode_intt, r4_ntt ? a1 : a2, a3,
                    mode_r4 ? (mode_intt ? w2 : w0) : w1);
    l2a_d  = mode_intt ? w0 : w1;
    l2b_d  = mode_intt ? w0 : w2;
  end

  // Layer 1 reduce; radix-4 NTT writes its butterflies to the (0,2)/(1,3) positions.
  always_comb begin
    pa = bf_red(gs_1_q, hv_1_q, ma_1_q);
    pb = bf_red(gs_1_q, hv_1_q, mb_1_q);
    if (r4_1_q && !gs_1_q) begin
      b_d[0] = pa.hi;
      b_d[2] = pa.lo;
      b_d[1] = pb.hi;
      b_d[3] = pb.lo;
    end else begin
      b_d[0] = pa.hi;
      b_d[1] = pa.lo;
      b_d[2] = pb.hi;
      b_d[3] = pb.lo;
    end
  end

  // Layer 2 multiply: NTT pairs (0,1)/(2,3), INTT pairs (0,2)/(1,3).
  always_comb begin
    if (gs_2_q) begin
      ma_3_d = bf_mul(1'b1, b_2_q[0], b_2_q[2], l2a_2_q);
      mb_3_d = bf_mul(1'b1, b_2_q[1], b_2_q[3], l2b_2_q);
    end else begin
      ma_3_d = bf_mul(1'b0, b_2_q[0], b_2_q[1], l2a_2_q);
      mb_3_d = bf_mul(1'b0, b_2_q[2], b_2_q[3], l2b_2_q);
    end
  end

  // Layer 2 reduce, or plain bypass of the layer-1 result in radix-2 mode.
  always_comb begin
    qa = bf_red(gs_3_q, hv_3_q, ma_3_q);
    qb = bf_red(gs_3_q, hv_3_q, mb_3_q);
    y_d = byp_3_q;
    if (r4_3_q) begin
      if (gs_3_q) begin
        y_d[0] = qa.hi;
        y_d[2] = qa.lo;
        y_d[1] = qb.hi;
        y_d[3] = qb.lo;
      end else begin
        y_d[0] = qa.hi;
        y_d[1] = qa.lo;
        y_d[2] = qb.hi;
        y_d[3] = qb.lo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      r4_1_q  <= 1'b0;
      gs_1_q  <= 1'b0;
      hv_1_q  <= 1'b0;
      r4_2_q  <= 1'b0;
      gs_2_q  <= 1'b0;
      hv_2_q  <= 1'b0;
      r4_3_q  <= 1'b0;
      gs_3_q  <= 1'b0;
      hv_3_q  <= 1'b0;
      ma_1_q  <= '0;
      mb_1_q  <= '0;
      ma_3_q  <= '0;
      mb_3_q  <= '0;
      l2a_1_q <= '0;
      l2b_1_q <= '0;
      l2a_2_q <= '0;
      l2b_2_q <= '0;
      for (int i = 0; i < 4; i++) begin
        b_2_q[i]   <= '0;
        byp_3_q[i] <= '0;
        y_q[i]     <= '0;
      end
    end else if (!stall) begin
      v1_q <= in_valid;
      if (in_valid) begin
        r4_1_q  <= mode_r4;
        gs_1_q  <= mode_intt;
        hv_1_q  <= mode_intt & halve;
        ma_1_q  <= ma_1_d;
        mb_1_q  <= mb_1_d;
        l2a_1_q <= l2a_d;
        l2b_1_q <= l2b_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        r4_2_q  <= r4_1_q;
        gs_2_q  <= gs_1_q;
        hv_2_q  <= hv_1_q;
        l2a_2_q <= l2a_1_q;
        l2b_2_q <= l2b_1_q;
        b_2_q   <= b_d;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        r4_3_q  <= r4_2_q;
        gs_3_q  <= gs_2_q;
        hv_3_q  <= hv_2_q;
        ma_3_q  <= ma_3_d;
        mb_3_q  <= mb_3_d;
        byp_3_q <= b_2_q;
      end
      v4_q <= v3_q;
      // y only loads on a real beat so it holds the last valid result across bubbles.
      if (v3_q) y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_compact_bf_pipe.sv
module tb_compact_bf_pipe;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, mode_r4, mode_intt, halve;
  int   ca [4];
  int   cw [3];
  int   da [4];
  int   dw [3];

  logic [13:0] a0, a1, a2, a3, w0, w1, w2, y0, y1, y2, y3;
  logic [11:0] a0_b, a1_b, a2_b, a3_b, w0_b, w1_b, w2_b, y0_b, y1_b, y2_b, y3_b;
  logic        in_ready, out_valid, in_ready_b, out_valid_b;

  assign a0 = 14'(ca[0]);
  assign a1 = 14'(ca[1]);
  assign a2 = 14'(ca[2]);
  assign a3 = 14'(ca[3]);
  assign w0 = 14'(cw[0]);
  assign w1 = 14'(cw[1]);
  assign w2 = 14'(cw[2]);
  assign a0_b = 12'(da[0]);
  assign a1_b = 12'(da[1]);
  assign a2_b = 12'(da[2]);
  assign a3_b = 12'(da[3]);
  assign w0_b = 12'(dw[0]);
  assign w1_b = 12'(dw[1]);
  assign w2_b = 12'(dw[2]);

  compact_bf_pipe #(.DATA_WIDTH(14), .Q(12289)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode_r4(mode_r4), .mode_intt(mode_intt), .halve(halve),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .w0(w0), .w1(w1), .w2(w2),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  compact_bf_pipe #(.DATA_WIDTH(12), .Q(3329)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .mode_r4(mode_r4), .mode_intt(mode_intt), .halve(halve),
    .a0(a0_b), .a1(a1_b), .a2(a2_b), .a3(a3_b), .w0(w0_b), .w1(w1_b), .w2(w2_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .y0(y0_b), .y1(y1_b), .y2(y2_b), .y3(y3_b)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_out    = 0;
  bit          acc      = 1'b0;
  logic [63:0] exp_q   [$];
  logic [63:0] exp_b_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference arithmetic straight from the butterfly definitions.
  function automatic int md(input longint x, input int q);
    longint r;
    r = x % q;
    if (r < 0) r = r + q;
    return int'(r);
  endfunction

  function automatic int half(input int x, input int q);
    return (x % 2 == 0) ? x / 2 : (x + q) / 2;
  endfunction

  function automatic void bf(input int u, input int v, input int w, input int q, input bit gs,
                             input bit hv, output int hi, output int lo);
    int t;
    if (!gs) begin
      t  = md(longint'(v) * w, q);
      hi = md(longint'(u + t), q);
      lo = md(longint'(u - t), q);
    end else begin
      hi = md(longint'(u + v), q);
      lo = md(longint'(md(longint'(u - v), q)) * w, q);
      if (hv) begin
        hi = half(hi, q);
        lo = half(lo, q);
      end
    end
  endfunction

  function automatic logic [63:0] pk(input int y0v, input int y1v, input int y2v, input int y3v);
    return {16'(y0v), 16'(y1v), 16'(y2v), 16'(y3v)};
  endfunction

  // Applies a table of (i, j, twiddle) butterflies in order over the coefficient vector.
  function automatic logic [63:0] model(input int q, input int a[4], input int w[3],
                                        input bit r4, input bit intt, input bit hvin);
    int x [4];
    int li [4];
    int lj [4];
    int lw [4];
    int nl;
    int h, l;
    bit hv;
    x  = a;
    hv = intt & hvin;
    if (!r4) begin
      nl = 2;
      li = '{0, 2, 0, 0}; lj = '{1, 3, 0, 0}; lw = '{w[0], w[1], 0, 0};
    end else if (!intt) begin
      nl = 4;
      li = '{0, 1, 0, 2}; lj = '{2, 3, 1, 3}; lw = '{w[0], w[0], w[1], w[2]};
    end else begin
      nl = 4;
      li = '{0, 2, 0, 1}; lj = '{1, 3, 2, 3}; lw = '{w[1], w[2], w[0], w[0]};
    end
    for (int k = 0; k < nl; k++) begin
      bf(x[li[k]], x[lj[k]], lw[k], q, intt, hv, h, l);
      x[li[k]] = h;
      x[lj[k]] = l;
    end
    return pk(x[0], x[1], x[2], x[3]);
  endfunction

  // One clock: observe handshakes just before the rising edge, return at the falling edge.
  task automatic cycle();
    #4;
    acc = in_valid && in_ready;
    if (out_valid && !out_ready) check("stall_in_ready", {63'b0, in_ready}, 64'd0);
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_out", {63'b0, out_valid}, 64'd0);
      else check("y_q12289", {2'b0, y0, 2'b0, y1, 2'b0, y2, 2'b0, y3}, exp_q.pop_front());
    end
    if (out_valid_b && out_ready) begin
      if (exp_b_q.size() == 0) check("spurious_out_b", {63'b0, out_valid_b}, 64'd0);
      else check("y_q3329", {4'b0, y0_b, 4'b0, y1_b, 4'b0, y2_b, 4'b0, y3_b},
                 exp_b_q.pop_front());
    end
    if (acc) exp_q.push_back(model(12289, ca, cw, mode_r4, mode_intt, halve));
    if (in_valid && in_ready_b) exp_b_q.push_back(model(3329, da, dw, mode_r4, mode_intt, halve));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_b();
    for (int i = 0; i < 4; i++) da[i] = int'($urandom_range(0, 3328));
    for (int i = 0; i < 3; i++) dw[i] = int'($urandom_range(0, 3328));
  endtask

  task automatic rand_beat();
    for (int i = 0; i < 4; i++) ca[i] = int'($urandom_range(0, 12288));
    for (int i = 0; i < 3; i++) cw[i] = int'($urandom_range(0, 12288));
    rand_b();
    mode_r4   = 1'($urandom_range(0, 1));
    mode_intt = 1'($urandom_range(0, 1));
    halve     = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < 50) begin
      cycle();
      n++;
    end
    check(tag, 64'(exp_q.size() + exp_b_q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input int a[4], input int w[3], input bit r4,
                          input bit intt, input bit hv, input logic [63:0] expv);
    int n;
    ca = a;
    cw = w;
    rand_b();
    mode_r4   = r4;
    mode_intt = intt;
    halve     = hv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    check({tag, "_accept"}, {63'b0, acc}, 64'd1);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_y"}, {2'b0, y0, 2'b0, y1, 2'b0, y2, 2'b0, y3}, expv);
    drain({tag, "_drain"});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, n_acc, n0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode_r4 = 1'b0;
    mode_intt = 1'b0;
    halve = 1'b0;
    ca = '{0, 0, 0, 0};
    cw = '{0, 0, 0};
    da = '{0, 0, 0, 0};
    dw = '{0, 0, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", {62'b0, out_valid, out_valid_b}, 64'd0);
    check("reset_y", {2'b0, y0, 2'b0, y1, 2'b0, y2, 2'b0, y3}, 64'd0);
    check("reset_y_b", {4'b0, y0_b, 4'b0, y1_b, 4'b0, y2_b, 4'b0, y3_b}, 64'd0);
    check("reset_in_ready", {62'b0, in_ready, in_ready_b}, 64'd3);
    @(negedge clk);

    directed("r2_ntt", '{1, 2, 12288, 1}, '{3, 1, 0}, 1'b0, 1'b0, 1'b0,
             pk(7, 12284, 0, 12287));
    directed("r2_intt_halve", '{5, 3, 4, 3}, '{2, 1, 0}, 1'b0, 1'b1, 1'b1,
             pk(4, 2, 6148, 6145));
    directed("r2_intt", '{5, 3, 4, 3}, '{2, 1, 0}, 1'b0, 1'b1, 1'b0, pk(8, 4, 7, 1));
    directed("r2_ntt_halve_ignored", '{1, 2, 12288, 1}, '{3, 1, 0}, 1'b0, 1'b0, 1'b1,
             pk(7, 12284, 0, 12287));
    directed("r4_ntt", '{1, 2, 3, 4}, '{1, 1, 1}, 1'b1, 1'b0, 1'b0,
             pk(10, 12287, 12285, 0));
    directed("r4_intt", '{1, 2, 3, 4}, '{2, 1, 1}, 1'b1, 1'b1, 1'b0,
             pk(10, 12287, 12281, 0));

    // Back-pressure: 8 back-to-back beats, out_ready low for 3 cycles mid-stream.
    n0 = int'(n_out);
    k = 0;
    t = 0;
    rand_beat();
    in_valid = 1'b1;
    while (k < 8 && t < 40) begin
      out_ready = !(t >= 5 && t < 8);
      cycle();
      if (acc) begin
        k++;
        if (k < 8) rand_beat();
        else in_valid = 1'b0;
      end
      t++;
    end
    check("bp_accepted", 64'(k), 64'd8);
    drain("bp_drain");
    check("bp_out_count", 64'(int'(n_out) - n0), 64'd8);

    // Reset mid-stream: beat 1 at the output, three more in flight.
    ca = '{1, 2, 3, 4};
    cw = '{1, 1, 1};
    rand_b();
    mode_r4 = 1'b1;
    mode_intt = 1'b0;
    halve = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (4) cycle();
    in_valid = 1'b0;
    check("pre_reset_y", {2'b0, y0, 2'b0, y1, 2'b0, y2, 2'b0, y3}, pk(10, 12287, 12285, 0));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_valid", {62'b0, out_valid, out_valid_b}, 64'd0);
    check("async_reset_y", {2'b0, y0, 2'b0, y1, 2'b0, y2, 2'b0, y3}, 64'd0);
    check("async_reset_y_b", {4'b0, y0_b, 4'b0, y1_b, 4'b0, y2_b, 4'b0, y3_b}, 64'd0);
    exp_q.delete();
    exp_b_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = int'(n_out);
    repeat (10) cycle();
    check("no_stale_beat", 64'(int'(n_out) - n0), 64'd0);
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Random soak on both moduli with random valid/ready.
    n_acc = 0;
    t = 0;
    in_valid = 1'b0;
    acc = 1'b0;
    while (n_acc < 10000 && t < 40000) begin
      if (!in_valid || acc) begin
        rand_beat();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc) n_acc++;
      t++;
    end
    check("soak_accepted", 64'(n_acc), 64'd10000);
    drain("soak_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
